bus8088_master: RTL

BUS8088_MASTER -- requirements
Module: bus8088_master

---
 rtl/bus8088_pkg.sv | 27 ++
 rtl/bus8088_master.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/bus8088_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : bus8088_pkg
//  Description : Shared types and constants for the 8088-style bus master.
//                - state_t     : one-hot bus state (TI, T1, T2, T3, TW, T4)
//                - ADDR_W      : address bus width
//                - DATA_W      : data bus width
//                - CS_BOUNDARY : first address of the upper memory bank
//  Revision    : 1.0 - initial release
// ============================================================================
package bus8088_pkg;

  localparam int ADDR_W = 20;
  localparam int DATA_W = 8;
  localparam logic [ADDR_W-1:0] CS_BOUNDARY = 20'h80000;

  typedef enum logic [5:0] {
    ST_TI = 6'b000001,
    ST_T1 = 6'b000010,
    ST_T2 = 6'b000100,
    ST_T3 = 6'b001000,
    ST_TW = 6'b010000,
    ST_T4 = 6'b100000
  } state_t;

endpackage
`default_nettype wire

// File: rtl/bus8088_master.sv
`default_nettype none
// ============================================================================
//  Module      : bus8088_master
//  Description : Single-request 8088-style bus cycle generator. Runs
//                T1-T2-T3-[TW...]-T4 per accepted request and returns a
//                one-cycle completion pulse in T4. Wait states are counted
//                and the cycle is aborted after MAX_WAIT of them.
//  Ports       : clk, reset (async, active-low)
//                req_*   : request handshake (valid/ready, write, io, addr, wdata)
//                rsp_*   : completion (valid pulse, read data, timeout flag)
//                ready   : slave READY input
//                ale/iom/cs/rd/wr/den/addr/data : bus pins (strobes active-low)
//  Revision    : 1.0 - initial release
// ============================================================================
module bus8088_master
  import bus8088_pkg::*;
#(
  parameter int                MAX_WAIT    = 15,
  parameter logic [ADDR_W-1:0] CS_BOUNDARY = bus8088_pkg::CS_BOUNDARY
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic              req_io,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  input  logic              ready,
  output logic              ale,
  output logic              iom,
  output logic              cs,
  output logic              rd,
  output logic              wr,
  output logic              den,
  output logic [0:ADDR_W-1] addr,
  inout  wire  [DATA_W-1:0] data
);

  // Wide enough to hold MAX_WAIT itself; the counter never exceeds it.
  localparam int WAIT_W = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);

  state_t              state_q, state_d;
  logic [WAIT_W-1:0]   wcnt_q, wcnt_d;
  logic                abort_d;
  logic                accept;
  logic                strobe_d;
  logic                data_ph_d;

  logic                write_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [ADDR_W-1:0]   addr_q;
  logic                iom_q, cs_q;
  logic                req_ready_q, ale_q, rd_q, wr_q, den_q, oe_q;
  logic                rsp_valid_q, rsp_err_q;
  logic [DATA_W-1:0]   rsp_rdata_q;

  assign accept = req_valid && req_ready_q;

  // Next-state and wait-counter logic.
  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    abort_d = 1'b0;
    unique case (state_q)
      ST_TI: begin
        if (accept) begin
          state_d = ST_T1;
          wcnt_d  = '0;
        end
      end
      ST_T1: begin
        state_d = ST_T2;
        wcnt_d  = '0;
      end
      ST_T2: state_d = ST_T3;
      ST_T3, ST_TW: begin
        if (ready) begin
          state_d = ST_T4;
        end else if (wcnt_q < WAIT_MAX) begin
          state_d = ST_TW;
          wcnt_d  = wcnt_q + 1'b1;
        end else begin
          state_d = ST_T4;
          abort_d = 1'b1;
        end
      end
      ST_T4: begin
        if (accept) begin
          state_d = ST_T1;
          wcnt_d  = '0;
        end else begin
          state_d = ST_TI;
        end
      end
      default: state_d = ST_TI;
    endcase
  end

  // Only T1 is ever entered via accept, so in T2..T4 the latched write
  // flag is already the one that applies to the next cycle.
  assign strobe_d  = (state_d == ST_T2) || (state_d == ST_T3) || (state_d == ST_TW);
  assign data_ph_d = strobe_d || (state_d == ST_T4);

  // All bus outputs are registered from the next state so pins change
  // cleanly on the clock edge that enters each T-state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_TI;
      wcnt_q      <= '0;
      write_q     <= 1'b0;
      wdata_q     <= '0;
      addr_q      <= '0;
      iom_q       <= 1'b0;
      cs_q        <= 1'b0;
      req_ready_q <= 1'b0;
      ale_q       <= 1'b0;
      rd_q        <= 1'b1;
      wr_q        <= 1'b1;
      den_q       <= 1'b1;
      oe_q        <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;

      if (accept) begin
        write_q <= req_write;
        wdata_q <= req_wdata;
        addr_q  <= req_addr;
        iom_q   <= req_io;
        cs_q    <= (req_addr >= CS_BOUNDARY);
      end

      req_ready_q <= (state_d == ST_TI) || (state_d == ST_T4);
      ale_q       <= (state_d == ST_T1);
      rd_q        <= !(strobe_d && !write_q);
      wr_q        <= !(strobe_d && write_q);
      den_q       <= !(strobe_d || ((state_d == ST_T4) && write_q));
      oe_q        <= data_ph_d && write_q;
      rsp_valid_q <= (state_d == ST_T4);

      // T4 is only reached from T3/TW: capture the completion status.
      if (state_d == ST_T4) begin
        rsp_err_q   <= abort_d;
        rsp_rdata_q <= (!write_q && !abort_d) ? data : '0;
      end
    end
  end

  assign req_ready = req_ready_q;
  assign ale       = ale_q;
  assign iom       = iom_q;
  assign cs        = cs_q;
  assign rd        = rd_q;
  assign wr        = wr_q;
  assign den       = den_q;
  assign addr      = addr_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = rsp_rdata_q;
  assign data      = oe_q ? wdata_q : {DATA_W{1'bz}};

endmodule
`default_nettype wire
